// File: rtl/rgb_seq_ctrl.sv
// rgb_seq_ctrl: 7-colour palette sequencer for the board RGB LED path. Optional cross-fade via `define RGB_SEQ_FADE_EN.
// Latency: step_pulse_i is registered, then accepted on the next edge; the colour loads at once or fades at tick rate.
// Backpressure: none upstream. During a fade one step is held pending and further steps are dropped.
module rgb_seq_ctrl #(
  parameter int TICK_DIV   = 1000000,
  parameter int AUTO_DWELL = 200
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        step_pulse_i,
  input  logic        dir_i,
  input  logic        auto_en_i,
  output logic [2:0]  color_idx_o,
  output logic [23:0] color_out_o,
  output logic        busy_o,
  output logic        tick_out_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(AUTO_DWELL + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_TICK = PW'(TICK_DIV - 2);
  localparam logic [DW-1:0] DW_LAST  = DW'(AUTO_DWELL - 1);

  function automatic logic [23:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    return 24'h7F0000;
      3'd1:    return 24'h7F5200;
      3'd2:    return 24'h7F7F00;
      3'd3:    return 24'h007F00;
      3'd4:    return 24'h00007F;
      3'd5:    return 24'h250041;
      3'd6:    return 24'h774177;
      default: return 24'h7F0000;
    endcase
  endfunction

  // Mod-7 index step; 7 is never produced.
  function automatic logic [2:0] idx_step(input logic [2:0] i, input logic fwd);
    if (fwd) return (i == 3'd6) ? 3'd0 : i + 3'd1;
    return (i == 3'd0) ? 3'd6 : i - 3'd1;
  endfunction

  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic [DW-1:0] dwell_q;
  logic          step_q;
  logic          dir_q;
  logic [2:0]    idx_q;
  logic [23:0]   color_q;
  logic          hold;
  logic          auto_fire;
  logic          take;
  logic          take_dir;
  logic [2:0]    nxt_idx;

`ifdef RGB_SEQ_FADE_EN
  typedef enum logic {S_HOLD, S_FADE} state_t;
  state_t        state_q;
  logic          pend_q;
  logic          pend_dir_q;
  logic          busy_q;
  logic [23:0]   target;
  logic [23:0]   faded;
`endif

  // Free-running prescaler; tick is registered so it is high while the count sits at TICK_DIV-1.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
      tick_q  <= (presc_q == PRE_TICK);
    end
  end

  // Register the step request and its direction together so dir is sampled with the step.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      step_q <= 1'b0;
      dir_q  <= 1'b1;
    end else begin
      step_q <= step_pulse_i;
      dir_q  <= dir_i;
    end
  end

  // Decide whether a step is taken this cycle; a pending step wins over a new pulse or dwell expiry.
  always_comb begin
`ifdef RGB_SEQ_FADE_EN
    hold = (state_q == S_HOLD);
`else
    hold = 1'b1;
`endif
    auto_fire = hold && auto_en_i && tick_q && (dwell_q == DW_LAST);
    take      = 1'b0;
    take_dir  = dir_q;
    if (hold && (step_q || auto_fire)) take = 1'b1;
`ifdef RGB_SEQ_FADE_EN
    if (hold && pend_q) begin
      take     = 1'b1;
      take_dir = pend_dir_q;
    end
    target = palette(idx_q);
    faded  = {ch_step(color_q[23:16], target[23:16]),
              ch_step(color_q[15:8],  target[15:8]),
              ch_step(color_q[7:0],   target[7:0])};
`endif
    nxt_idx = idx_step(idx_q, take_dir);
  end

`ifdef RGB_SEQ_FADE_EN
  // Move one channel a single unit toward its target.
  function automatic logic [7:0] ch_step(input logic [7:0] c, input logic [7:0] t);
    if (c < t) return c + 8'd1;
    if (c > t) return c - 8'd1;
    return c;
  endfunction
`endif

  // Sequencer FSM: index, colour word, dwell counter and (with fade) state/pending/busy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q      <= 3'd0;
      color_q    <= 24'h7F0000;
      dwell_q    <= '0;
`ifdef RGB_SEQ_FADE_EN
      state_q    <= S_HOLD;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      busy_q     <= 1'b0;
`endif
    end else begin
      if (take || !auto_en_i || !hold) dwell_q <= '0;
      else if (tick_q)                 dwell_q <= dwell_q + DW'(1);
      if (take) idx_q <= nxt_idx;
`ifdef RGB_SEQ_FADE_EN
      case (state_q)
        S_HOLD: begin
          if (take) begin
            state_q <= S_FADE;
            busy_q  <= 1'b1;
          end
          // A pulse arriving with the pending step takes its place in the pending slot.
          if (pend_q) begin
            pend_q <= step_q;
            if (step_q) pend_dir_q <= dir_q;
          end
        end
        S_FADE: begin
          if (tick_q) begin
            color_q <= faded;
            if (faded == target) begin
              state_q <= S_HOLD;
              busy_q  <= 1'b0;
            end
          end
          if (step_q && !pend_q) begin
            pend_q     <= 1'b1;
            pend_dir_q <= dir_q;
          end
        end
        default: state_q <= S_HOLD;
      endcase
`else
      if (take) color_q <= palette(nxt_idx);
`endif
    end
  end

  assign color_idx_o = idx_q;
  assign color_out_o = color_q;
  assign tick_out_o  = tick_q;
`ifdef RGB_SEQ_FADE_EN
  assign busy_o      = busy_q;
`else
  assign busy_o      = 1'b0;
`endif

endmodule
